rgb_pwm_fader: RTL and testbench
================================

RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 CHANNELS, 3, number of independent PWM channels (>=1).
REQ-002 DUTY_W, 4, level/target width per channel (2..8); PWM period P = 2^DUTY_W-1 cycles.
REQ-003 RATE_W, 8, width of the rate input.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 mode  input  2  00 STATIC, 01 FADE, 10 BLINK, 11 treated as STATIC.
REQ-007 target  input  CHANNELS*DUTY_W  requested level, channel i at bits [i*DUTY_W +: DUTY_W].
REQ-008 rate  input  RATE_W  step/blink interval in PWM periods, minus one.
REQ-009 load_valid  input  1  target is valid this cycle.
REQ-010 load_ready  output  1  block accepts target this cycle.
REQ-011 pwm_out  output  CHANNELS  registered PWM drive, bit i = channel i.
REQ-012 level  output  CHANNELS*DUTY_W  current applied level per channel.
REQ-013 period_tick  output  1  one-cycle pulse on the last cycle of each PWM period.
REQ-014 busy  output  1  high while in FADING.

Function
REQ-015 Shared period counter cnt counts 0..P-1 and wraps to 0; period_tick = (cnt == P-1).
REQ-016 pwm_out[i] registered as (cnt < level[i]); one-cycle latency; level 0 = never high, level P = always high.
REQ-017 Handshake: transfer when load_valid && load_ready; target captured into tgt_q on that edge; load_valid ignored when load_ready low.
REQ-018 load_ready high in IDLE, BLINK_ON, BLINK_OFF; low in FADING.
REQ-019 mode sampled into mode_q only on period_tick edges; mode change mid-period has no effect until the boundary.
REQ-020 All level updates occur only on period_tick edges (glitch-free PWM).
REQ-021 Interval counter ivl counts period_ticks 0..rate; an "interval event" is a period_tick with ivl == rate, then ivl resets to 0; rate = 0 gives an event every period.
REQ-022 FSM states IDLE, FADING, BLINK_ON, BLINK_OFF.
REQ-023 IDLE, mode_q STATIC: level <= tgt_q on next period_tick; remain IDLE.
REQ-024 IDLE, mode_q FADE, level != tgt_q: go FADING at period_tick, ivl cleared.
REQ-025 FADING: on each interval event every channel with level != tgt moves exactly 1 toward tgt; when all equal after the step, return to IDLE.
REQ-026 IDLE, mode_q BLINK: go BLINK_ON at period_tick with level <= tgt_q.
REQ-027 BLINK_ON -> BLINK_OFF on interval event, level <= 0; BLINK_OFF -> BLINK_ON on interval event, level <= tgt_q (newest accepted target).
REQ-028 In any BLINK state, mode_q != BLINK at period_tick -> IDLE, level unchanged that edge.
REQ-029 Transfer on the same edge as period_tick: boundary logic uses pre-load tgt_q; new value applies at the next boundary.
REQ-030 Level arithmetic never wraps: step saturates at tgt; no value outside 0..P ever appears on level (targets above P clamp to P on capture).

Reset
REQ-031 rst high: cnt=0, ivl=0, state=IDLE, mode_q=STATIC, tgt_q=0, level=0, pwm_out=0, period_tick=0, busy=0; load_ready=1 after release.
REQ-032 Reset asserted mid-fade or mid-blink aborts immediately; first period after release starts at cnt=0.

Structure
REQ-033 Package rgb_pwm_pkg holds the mode enum, FSM state enum, and the P-from-DUTY_W function.
REQ-034 One sub-module pwm_channel (per-channel level register, step-toward logic, comparator), generated CHANNELS times; shared counter, interval counter, FSM in top.

Verification (CHANNELS=3, DUTY_W=4, P=15)
REQ-035 STATIC, load {15,7,0} -> from next boundary pwm_out high 15/7/0 of every 15 cycles; period_tick every 15 cycles.
REQ-036 FADE, rate=1, level 0, load ch0=3 -> busy, level 1,2,3 at every 2nd period_tick, then IDLE, load_ready high; load_valid during fade not accepted.
REQ-037 BLINK, rate=0, target 9 -> level alternates 9/0 each period; load 4 during BLINK_ON -> next ON phase uses 4.
REQ-038 load_valid coincident with period_tick in STATIC -> old level kept one more period, new level at following boundary.
REQ-039 rst asserted mid-fade (level 2 of 5) -> all outputs 0 asynchronously, state IDLE, cnt restarts at 0.
REQ-040 Target 15 vs 0 on ch1 in FADE with rate=0 -> monotone 15 steps, no overshoot or wrap.

Source files
------------

// File: rtl/rgb_pwm_fader_pkg.sv
// Shared types for the RGB PWM fader: operating modes, controller states,
// per-channel level commands and the PWM period helper.
package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_FADE   = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    FADING,
    BLINK_ON,
    BLINK_OFF
  } state_e;

  typedef enum logic [1:0] {
    LV_HOLD,
    LV_LOAD,
    LV_ZERO,
    LV_STEP
  } lvl_cmd_e;

  function automatic int unsigned period_of(input int unsigned duty_w);
    return (32'd1 << duty_w) - 32'd1;
  endfunction

endpackage

// File: rtl/rgb_pwm_fader_channel.sv
// One PWM channel: applied level register, single-step-toward-target logic
// and the registered duty comparator against the shared period counter.
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned DUTY_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] cnt,
  input  logic [DUTY_W-1:0] tgt,
  input  lvl_cmd_e          cmd,
  output logic [DUTY_W-1:0] level,
  output logic              pwm,
  output logic              at_tgt,
  output logic              settled
);

  logic [DUTY_W-1:0] step_val;

  // Stepping by one toward tgt can never overshoot or wrap.
  always_comb begin
    step_val = level;
    if (level < tgt) begin
      step_val = level + 1'b1;
    end else if (level > tgt) begin
      step_val = level - 1'b1;
    end
  end

  assign at_tgt  = (level == tgt);
  assign settled = (step_val == tgt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
      pwm   <= 1'b0;
    end else begin
      pwm <= (cnt < level);
      case (cmd)
        LV_LOAD: level <= tgt;
        LV_ZERO: level <= '0;
        LV_STEP: level <= step_val;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rgb_pwm_fader.sv
// Multi-channel PWM fader: shared period and interval counters plus the
// STATIC / FADE / BLINK controller; level changes only at period boundaries.
module rgb_pwm_fader
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DUTY_W   = 4,
  parameter int unsigned RATE_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic [CHANNELS*DUTY_W-1:0]   target,
  input  logic [RATE_W-1:0]            rate,
  input  logic                         load_valid,
  output logic                         load_ready,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic [CHANNELS*DUTY_W-1:0]   level,
  output logic                         period_tick,
  output logic                         busy
);

  localparam int unsigned       P      = period_of(DUTY_W);
  localparam logic [DUTY_W-1:0] P_LAST = DUTY_W'(P - 1);

  logic [DUTY_W-1:0]          cnt;
  logic [RATE_W-1:0]          ivl;
  logic [CHANNELS*DUTY_W-1:0] tgt_q;
  mode_e                      mode_q;
  state_e                     state, state_nxt;
  lvl_cmd_e                   cmd;
  logic                       xfer, ivl_event;
  logic [CHANNELS-1:0]        at_tgt, settled;

  assign period_tick = (cnt == P_LAST);
  assign load_ready  = (state != FADING);
  assign busy        = (state == FADING);
  assign xfer        = load_valid && load_ready;
  assign ivl_event   = period_tick && (ivl >= rate);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= period_tick ? '0 : cnt + 1'b1;
    end
  end

  // A DUTY_W-bit target cannot exceed P, so capture needs no clamp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_STATIC;
      tgt_q  <= '0;
    end else begin
      if (period_tick) mode_q <= mode_e'(mode);
      if (xfer)        tgt_q  <= target;
    end
  end

  // Interval counter idles at zero so every fade/blink starts a fresh interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ivl <= '0;
    end else if (state == IDLE) begin
      ivl <= '0;
    end else if (period_tick) begin
      ivl <= ivl_event ? '0 : ivl + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd       = LV_HOLD;
    if (period_tick) begin
      case (state)
        IDLE: begin
          case (mode_q)
            MODE_FADE: begin
              if (!(&at_tgt)) state_nxt = FADING;
            end
            MODE_BLINK: begin
              state_nxt = BLINK_ON;
              cmd       = LV_LOAD;
            end
            default: cmd = LV_LOAD;
          endcase
        end
        FADING: begin
          if (ivl_event) begin
            cmd = LV_STEP;
            if (&settled) state_nxt = IDLE;
          end
        end
        BLINK_ON: begin
          if (mode_q != MODE_BLINK) begin
            state_nxt = IDLE;
          end else if (ivl_event) begin
            state_nxt = BLINK_OFF;
            cmd       = LV_ZERO;
          end
        end
        BLINK_OFF: begin
          if (mode_q != MODE_BLINK) begin
            state_nxt = IDLE;
          end else if (ivl_event) begin
            state_nxt = BLINK_ON;
            cmd       = LV_LOAD;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(.DUTY_W(DUTY_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .cnt     (cnt),
      .tgt     (tgt_q[i*DUTY_W +: DUTY_W]),
      .cmd     (cmd),
      .level   (level[i*DUTY_W +: DUTY_W]),
      .pwm     (pwm_out[i]),
      .at_tgt  (at_tgt[i]),
      .settled (settled[i])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader: expected per-boundary levels are queued
// as stimulus is applied and compared after each PWM period boundary.
module tb_rgb_pwm_fader;

  localparam int unsigned CH = 3;
  localparam int unsigned DW = 4;
  localparam int unsigned RW = 8;
  localparam int unsigned P  = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode;
  logic [CH*DW-1:0]  target;
  logic [RW-1:0]     rate;
  logic              load_valid;
  logic              load_ready;
  logic [CH-1:0]     pwm_out;
  logic [CH*DW-1:0]  level;
  logic              period_tick;
  logic              busy;

  rgb_pwm_fader #(.CHANNELS(CH), .DUTY_W(DW), .RATE_W(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .target      (target),
    .rate        (rate),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .pwm_out     (pwm_out),
    .level       (level),
    .period_tick (period_tick),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  typedef struct {
    string            tag;
    logic [CH*DW-1:0] lv;
    logic             bz;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH*DW-1:0] lv3(input logic [3:0] c2, input logic [3:0] c1,
                                           input logic [3:0] c0);
    return {c2, c1, c0};
  endfunction

  // Leaves the bench on the negedge of the cycle carrying period_tick.
  task automatic wait_tick();
    logic found;
    found = 1'b0;
    for (int k = 0; k < 2 * P; k++) begin
      @(negedge clk);
      if (period_tick) begin
        found = 1'b1;
        break;
      end
    end
    check("tick_seen", 32'(found), 32'd1);
  endtask

  task automatic next_period();
    wait_tick();
    @(negedge clk);
  endtask

  task automatic sb_push(input string tag, input logic [CH*DW-1:0] lv, input logic bz);
    exp_t e;
    e.tag = tag;
    e.lv  = lv;
    e.bz  = bz;
    sb.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (sb.size() != 0) begin
      next_period();
      e = sb.pop_front();
      check({e.tag, "_level"}, 32'(level), 32'(e.lv));
      check({e.tag, "_busy"}, 32'(busy), 32'(e.bz));
    end
  endtask

  task automatic load(input logic [CH*DW-1:0] v);
    target     = v;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic duty_check(input int unsigned e0, input int unsigned e1, input int unsigned e2);
    int unsigned h [CH];
    int unsigned ticks;
    ticks = 0;
    for (int i = 0; i < CH; i++) h[i] = 0;
    repeat (P) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) if (pwm_out[i]) h[i]++;
      if (period_tick) ticks++;
    end
    check("duty_ch0", h[0], e0);
    check("duty_ch1", h[1], e1);
    check("duty_ch2", h[2], e2);
    check("ticks_per_period", ticks, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned restart_k;
    rst        = 1'b1;
    mode       = 2'b00;
    target     = '0;
    rate       = '0;
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_tick", 32'(period_tick), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    check("rst_ready", 32'(load_ready), 32'd1);

    // STATIC load and duty measurement
    load(lv3(4'd0, 4'd7, 4'd15));
    sb_push("static", lv3(4'd0, 4'd7, 4'd15), 1'b0);
    sb_drain();
    duty_check(15, 7, 0);

    // Load coincident with period_tick: old level kept for one more period
    wait_tick();
    load(lv3(4'd0, 4'd0, 4'd5));
    check("coincident_old", 32'(level), 32'(lv3(4'd0, 4'd7, 4'd15)));
    sb_push("coincident_new", lv3(4'd0, 4'd0, 4'd5), 1'b0);
    sb_drain();

    // FADE rate=1 from 0 to 3 on ch0
    load('0);
    sb_push("zero", '0, 1'b0);
    sb_drain();
    mode = 2'b01;
    rate = 8'd1;
    sb_push("mode_fade", '0, 1'b0);
    sb_drain();
    load(lv3(4'd0, 4'd0, 4'd3));
    sb_push("fade_enter", '0, 1'b1);
    sb_drain();
    check("fade_ready_low", 32'(load_ready), 32'd0);
    load(lv3(4'd0, 4'd0, 4'd9));
    sb_push("fade_wait1", lv3(4'd0, 4'd0, 4'd0), 1'b1);
    sb_push("fade_step1", lv3(4'd0, 4'd0, 4'd1), 1'b1);
    sb_push("fade_wait2", lv3(4'd0, 4'd0, 4'd1), 1'b1);
    sb_push("fade_step2", lv3(4'd0, 4'd0, 4'd2), 1'b1);
    sb_push("fade_wait3", lv3(4'd0, 4'd0, 4'd2), 1'b1);
    sb_push("fade_step3", lv3(4'd0, 4'd0, 4'd3), 1'b0);
    sb_push("fade_hold", lv3(4'd0, 4'd0, 4'd3), 1'b0);
    sb_drain();
    check("fade_ready_high", 32'(load_ready), 32'd1);

    // FADE rate=0 on ch1: 0 -> 15 -> 0, one step per period
    rate = 8'd0;
    load(lv3(4'd0, 4'd15, 4'd3));
    sb_push("up_enter", lv3(4'd0, 4'd0, 4'd3), 1'b1);
    for (int k = 1; k <= 15; k++) sb_push("fade_up", lv3(4'd0, 4'(k), 4'd3), k < 15);
    sb_push("up_hold", lv3(4'd0, 4'd15, 4'd3), 1'b0);
    sb_drain();
    load(lv3(4'd0, 4'd0, 4'd3));
    sb_push("down_enter", lv3(4'd0, 4'd15, 4'd3), 1'b1);
    for (int k = 14; k >= 0; k--) sb_push("fade_down", lv3(4'd0, 4'(k), 4'd3), k > 0);
    sb_push("down_hold", lv3(4'd0, 4'd0, 4'd3), 1'b0);
    sb_drain();

    // Reset in the middle of a fade toward 5 (at level 2)
    load('0);
    sb_push("pre_enter", lv3(4'd0, 4'd0, 4'd3), 1'b1);
    sb_push("pre_2", lv3(4'd0, 4'd0, 4'd2), 1'b1);
    sb_push("pre_1", lv3(4'd0, 4'd0, 4'd1), 1'b1);
    sb_push("pre_0", lv3(4'd0, 4'd0, 4'd0), 1'b0);
    sb_drain();
    load(lv3(4'd0, 4'd0, 4'd5));
    sb_push("mid_enter", lv3(4'd0, 4'd0, 4'd0), 1'b1);
    sb_push("mid_1", lv3(4'd0, 4'd0, 4'd1), 1'b1);
    sb_push("mid_2", lv3(4'd0, 4'd0, 4'd2), 1'b1);
    sb_drain();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_level", 32'(level), 32'd0);
    check("arst_pwm", 32'(pwm_out), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_tick", 32'(period_tick), 32'd0);
    check("arst_ready", 32'(load_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    restart_k = 0;
    for (int k = 1; k <= 2 * P; k++) begin
      @(negedge clk);
      if (period_tick) begin
        restart_k = k;
        break;
      end
    end
    check("restart_first_tick", restart_k, 32'd14);
    @(negedge clk);
    check("restart_level", 32'(level), 32'd0);
    check("restart_busy", 32'(busy), 32'd0);

    // BLINK rate=0, target 9 then 4 loaded during ON, then exit to STATIC
    mode = 2'b10;
    sb_push("blink_arm", '0, 1'b0);
    sb_drain();
    load(lv3(4'd0, 4'd0, 4'd9));
    sb_push("blink_on1", lv3(4'd0, 4'd0, 4'd9), 1'b0);
    sb_push("blink_off1", '0, 1'b0);
    sb_push("blink_on2", lv3(4'd0, 4'd0, 4'd9), 1'b0);
    sb_drain();
    load(lv3(4'd0, 4'd0, 4'd4));
    sb_push("blink_off2", '0, 1'b0);
    sb_push("blink_on3", lv3(4'd0, 4'd0, 4'd4), 1'b0);
    sb_drain();
    mode = 2'b00;
    sb_push("blink_off3", '0, 1'b0);
    sb_push("blink_exit", '0, 1'b0);
    sb_push("static_resume", lv3(4'd0, 4'd0, 4'd4), 1'b0);
    sb_drain();
    check("final_ready", 32'(load_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
